// File: rtl/window_frame_scheduler.sv
// Window-buffer shift gating and FFT frame pacing for the cyclostationary front end.
// Counts the initial fill and each L-sample hop, strobes frames, numbers them per block, flags drops.
module window_frame_scheduler #(
  parameter  int unsigned NP       = 64,
  parameter  int unsigned L        = 12,
  parameter  int unsigned N_FRAMES = 32,
  localparam int unsigned NB_FIDX  = $clog2(N_FRAMES)
) (
  input  logic               clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_continuous,
  input  logic               i_sample_valid,
  input  logic               i_fft_ready,
  output logic               o_shift_en,
  output logic               o_frame_valid,
  output logic [NB_FIDX-1:0] o_frame_idx,
  output logic               o_block_done,
  output logic               o_overrun,
  output logic               o_busy
);

  localparam int unsigned NB_FILL = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned NB_HOP  = (L > 1) ? $clog2(L) : 1;

  localparam logic [NB_FILL-1:0] FILL_LAST = NB_FILL'(NP - 1);
  localparam logic [NB_HOP-1:0]  HOP_LAST  = NB_HOP'(L - 1);
  localparam logic [NB_FIDX-1:0] FIDX_LAST = NB_FIDX'(N_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [NB_FILL-1:0] fill_cnt;
  logic [NB_FILL-1:0] fill_next;
  logic [NB_HOP-1:0]  hop_cnt;
  logic [NB_HOP-1:0]  hop_next;
  logic [NB_FIDX-1:0] fidx;
  logic [NB_FIDX-1:0] fidx_next;

  logic               frame_valid_next;
  logic [NB_FIDX-1:0] frame_idx_next;
  logic               block_done_next;
  logic               overrun_next;

  logic arm;
  logic accept;
  logic fill_term;
  logic hop_term;
  logic due;
  logic issue;
  logic drop;
  logic block_last;
  logic block_end;

  // Sample acceptance and frame-due decode; stop suppresses any due frame
  assign arm        = (state == IDLE) & i_start & ~i_stop;
  assign accept     = i_sample_valid & ((state == FILL) | (state == RUN));
  assign fill_term  = (state == FILL) & accept & (fill_cnt == FILL_LAST);
  assign hop_term   = (state == RUN) & accept & (hop_cnt == HOP_LAST);
  assign due        = (fill_term | hop_term) & ~i_stop;
  assign issue      = due & i_fft_ready;
  assign drop       = due & ~i_fft_ready;
  assign block_last = issue & (fidx == FIDX_LAST);
  assign block_end  = block_last & ~i_continuous;

  assign o_shift_en = accept;
  assign o_busy     = (state != IDLE);

  // State register
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (arm) state_next = FILL;
      end
      FILL: begin
        if (i_stop)         state_next = IDLE;
        else if (fill_term) state_next = RUN;
      end
      RUN: begin
        if (i_stop || block_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter and registered-output next values
  always_comb begin
    fill_next        = fill_cnt;
    hop_next         = hop_cnt;
    fidx_next        = fidx;
    frame_valid_next = issue;
    frame_idx_next   = o_frame_idx;
    block_done_next  = block_last;
    overrun_next     = o_overrun;

    if (issue) begin
      frame_idx_next = fidx;
      fidx_next      = block_last ? '0 : fidx + NB_FIDX'(1);
    end

    if (arm)       overrun_next = 1'b0;
    else if (drop) overrun_next = 1'b1;

    case (state)
      IDLE: begin
        fill_next = '0;
        hop_next  = '0;
        fidx_next = '0;
      end
      FILL: begin
        if (i_stop) begin
          fill_next = '0;
          hop_next  = '0;
          fidx_next = '0;
        end else if (accept) begin
          fill_next = fill_term ? '0 : fill_cnt + NB_FILL'(1);
          hop_next  = '0;
        end
      end
      RUN: begin
        if (i_stop || block_end) begin
          fill_next = '0;
          hop_next  = '0;
          fidx_next = '0;
        end else if (accept) begin
          hop_next = hop_term ? '0 : hop_cnt + NB_HOP'(1);
        end
      end
      default: begin
        fill_next = '0;
        hop_next  = '0;
        fidx_next = '0;
      end
    endcase
  end

  // Counters and registered outputs
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fill_cnt      <= '0;
      hop_cnt       <= '0;
      fidx          <= '0;
      o_frame_valid <= 1'b0;
      o_frame_idx   <= '0;
      o_block_done  <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      fill_cnt      <= fill_next;
      hop_cnt       <= hop_next;
      fidx          <= fidx_next;
      o_frame_valid <= frame_valid_next;
      o_frame_idx   <= frame_idx_next;
      o_block_done  <= block_done_next;
      o_overrun     <= overrun_next;
    end
  end

endmodule

// File: tb/tb_window_frame_scheduler.sv
// Bench for window_frame_scheduler: scenario tasks checked cycle by cycle against a
// sample-count model (frames due at sample NP, NP+L, NP+2L, ... since arming).
module tb_window_frame_scheduler;

  localparam int NP  = 64;
  localparam int LH  = 12;
  localparam int NF  = 4;
  localparam int NFI = $clog2(NF);

  logic           clock = 1'b0;
  logic           i_reset_n = 1'b0;
  logic           i_start = 1'b0;
  logic           i_stop = 1'b0;
  logic           i_continuous = 1'b0;
  logic           i_sample_valid = 1'b0;
  logic           i_fft_ready = 1'b0;
  logic           o_shift_en;
  logic           o_frame_valid;
  logic [NFI-1:0] o_frame_idx;
  logic           o_block_done;
  logic           o_overrun;
  logic           o_busy;

  window_frame_scheduler #(.NP(NP), .L(LH), .N_FRAMES(NF)) dut (
    .clock          (clock),
    .i_reset_n      (i_reset_n),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_continuous   (i_continuous),
    .i_sample_valid (i_sample_valid),
    .i_fft_ready    (i_fft_ready),
    .o_shift_en     (o_shift_en),
    .o_frame_valid  (o_frame_valid),
    .o_frame_idx    (o_frame_idx),
    .o_block_done   (o_block_done),
    .o_overrun      (o_overrun),
    .o_busy         (o_busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit             m_busy, m_sh, m_fv, m_bd, m_ovr;
  logic [NFI-1:0] m_idx;
  int             m_nsamp, m_next;
  logic           sh_seen;

  function automatic logic [NFI+4:0] seen();
    return {sh_seen, o_frame_valid, o_frame_idx, o_block_done, o_overrun, o_busy};
  endfunction

  function automatic logic [NFI+4:0] expv();
    return {m_sh, m_fv, m_idx, m_bd, m_ovr, m_busy};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_sh = 0; m_fv = 0; m_bd = 0; m_ovr = 0;
    m_idx = '0; m_nsamp = 0; m_next = 0;
  endtask

  // Apply one cycle of inputs (entered at posedge+1), advance the model, return at next posedge+1
  task automatic run_cycle(input bit st, input bit sp, input bit ct, input bit v, input bit rdy);
    i_start = st; i_stop = sp; i_continuous = ct; i_sample_valid = v; i_fft_ready = rdy;
    #2;
    sh_seen = o_shift_en;
    m_sh = m_busy & v;
    m_fv = 0;
    m_bd = 0;
    if (m_busy) begin
      if (sp) begin
        m_busy = 0;
        m_nsamp = 0;
      end else if (v) begin
        m_nsamp++;
        if (m_nsamp >= NP && (m_nsamp - NP) % LH == 0) begin
          if (rdy) begin
            m_fv = 1;
            m_idx = NFI'(m_next);
            m_bd = (m_next == NF - 1);
            m_next = (m_next + 1) % NF;
            if (m_bd && !ct) m_busy = 0;
          end else begin
            m_ovr = 1;
          end
        end
      end
    end else if (st && !sp) begin
      m_busy = 1; m_nsamp = 0; m_next = 0; m_ovr = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    i_start = 1; i_sample_valid = 1; i_fft_ready = 1;
    #12;
    sh_seen = o_shift_en;
    n_vec++;
    if (seen() !== expv()) begin
      n_err++; $display("FAIL reset_hold got=%b exp=%b", seen(), expv());
    end
    i_start = 0; i_sample_valid = 0;
    i_reset_n = 1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 1, 0, 1, 1);
      n_vec++;
      if (seen() !== expv()) begin
        n_err++; $display("FAIL reset_idle c%0d got=%b exp=%b", i, seen(), expv());
      end
    end
  endtask

  task automatic test_fill();
    int nstrobe = 0;
    run_cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < NP + LH; i++) begin
      run_cycle(0, 0, 0, 1, 1);
      n_vec++;
      if (seen() !== expv()) begin
        n_err++; $display("FAIL fill c%0d got=%b exp=%b", i, seen(), expv());
      end
      if (o_frame_valid) begin
        n_vec++;
        if ((nstrobe == 0 && (i != 63 || o_frame_idx !== 2'd0)) ||
            (nstrobe == 1 && (i != 75 || o_frame_idx !== 2'd1))) begin
          n_err++;
          $display("FAIL fill_strobe n%0d at sample %0d idx=%0d", nstrobe, i + 1, o_frame_idx);
        end
        nstrobe++;
      end
    end
    n_vec++;
    if (nstrobe != 2) begin
      n_err++; $display("FAIL fill_count got=%0d exp=2", nstrobe);
    end
    run_cycle(0, 1, 0, 0, 1);
    n_vec++;
    if (seen() !== expv()) begin
      n_err++; $display("FAIL fill_stop got=%b exp=%b", seen(), expv());
    end
  endtask

  task automatic test_gapped();
    int nstrobe = 0;
    run_cycle(1, 0, 1, 0, 1);
    for (int i = 0; i < (NP + 3 * LH) * 3; i++) begin
      run_cycle(0, 0, 1, (i % 3) == 2, 1);
      n_vec++;
      if (seen() !== expv()) begin
        n_err++; $display("FAIL gapped c%0d got=%b exp=%b", i, seen(), expv());
      end
      if (o_frame_valid) nstrobe++;
    end
    n_vec++;
    if (nstrobe != 4) begin
      n_err++; $display("FAIL gapped_count got=%0d exp=4", nstrobe);
    end
    run_cycle(0, 1, 0, 0, 1);
  endtask

  task automatic test_overrun();
    run_cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < NP + 4 * LH; i++) begin
      run_cycle(0, 0, 0, 1, !(i >= 76 && i < 88));
      n_vec++;
      if (seen() !== expv()) begin
        n_err++; $display("FAIL overrun c%0d got=%b exp=%b", i, seen(), expv());
      end
      if (i == 99) begin
        n_vec++;
        if (o_frame_valid !== 1'b1 || o_frame_idx !== 2'd2 || o_overrun !== 1'b1) begin
          n_err++;
          $display("FAIL overrun_next_frame fv=%b idx=%0d ovr=%b exp 1/2/1", o_frame_valid, o_frame_idx, o_overrun);
        end
      end
    end
    run_cycle(0, 0, 0, 0, 1);
    run_cycle(1, 0, 0, 0, 1);
    n_vec++;
    if (o_overrun !== 1'b0 || o_busy !== 1'b1) begin
      n_err++; $display("FAIL overrun_clear ovr=%b busy=%b exp 0/1", o_overrun, o_busy);
    end
    run_cycle(0, 1, 0, 0, 1);
  endtask

  task automatic test_block();
    run_cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < NP + 3 * LH + 2; i++) begin
      run_cycle(0, 0, 0, 1, 1);
      n_vec++;
      if (seen() !== expv()) begin
        n_err++; $display("FAIL block_single c%0d got=%b exp=%b", i, seen(), expv());
      end
      if (i == 99) begin
        n_vec++;
        if (o_frame_valid !== 1'b1 || o_frame_idx !== 2'd3 || o_block_done !== 1'b1) begin
          n_err++;
          $display("FAIL block_last fv=%b idx=%0d done=%b exp 1/3/1", o_frame_valid, o_frame_idx, o_block_done);
        end
      end
      if (i == 100) begin
        n_vec++;
        if (o_busy !== 1'b0 || sh_seen !== 1'b0) begin
          n_err++; $display("FAIL block_idle busy=%b shift=%b exp 0/0", o_busy, sh_seen);
        end
      end
    end
    run_cycle(1, 0, 1, 0, 1);
    for (int i = 0; i < NP + 4 * LH + 3; i++) begin
      run_cycle(0, 0, 1, 1, 1);
      n_vec++;
      if (seen() !== expv()) begin
        n_err++; $display("FAIL block_cont c%0d got=%b exp=%b", i, seen(), expv());
      end
      if (i == 111) begin
        n_vec++;
        if (o_frame_valid !== 1'b1 || o_frame_idx !== 2'd0 || o_busy !== 1'b1) begin
          n_err++;
          $display("FAIL block_wrap fv=%b idx=%0d busy=%b exp 1/0/1", o_frame_valid, o_frame_idx, o_busy);
        end
      end
    end
    run_cycle(0, 1, 0, 0, 1);
  endtask

  task automatic test_abort();
    run_cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < NP - 1; i++) run_cycle(0, 0, 0, 1, 1);
    run_cycle(1, 1, 0, 1, 1);
    n_vec++;
    if (seen() !== expv() || o_frame_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL abort_fill got=%b exp=%b", seen(), expv());
    end
    run_cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < NP + LH - 1; i++) run_cycle(0, 0, 0, 1, 1);
    run_cycle(0, 1, 0, 1, 1);
    n_vec++;
    if (seen() !== expv() || o_frame_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL abort_run got=%b exp=%b", seen(), expv());
    end
    run_cycle(1, 1, 0, 1, 1);
    run_cycle(0, 0, 0, 1, 1);
    n_vec++;
    if (seen() !== expv() || o_busy !== 1'b0 || sh_seen !== 1'b0) begin
      n_err++; $display("FAIL abort_start_stop got=%b exp=%b", seen(), expv());
    end
  endtask

  task automatic test_async_reset();
    run_cycle(1, 0, 1, 0, 1);
    for (int i = 0; i < NP + LH; i++) run_cycle(0, 0, 1, 1, 1);
    i_sample_valid = 1;
    #2;
    i_reset_n = 0;
    #1;
    model_reset();
    sh_seen = o_shift_en;
    n_vec++;
    if (seen() !== expv()) begin
      n_err++; $display("FAIL async_reset got=%b exp=%b", seen(), expv());
    end
    #2;
    i_reset_n = 1;
    i_sample_valid = 0;
    @(posedge clock);
    #1;
    run_cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < NP; i++) begin
      run_cycle(0, 0, 0, 1, 1);
      n_vec++;
      if (seen() !== expv() || (o_frame_valid !== (i == NP - 1))) begin
        n_err++; $display("FAIL restart_fill c%0d got=%b exp=%b", i, seen(), expv());
      end
    end
    run_cycle(0, 1, 0, 0, 1);
  endtask

  task automatic test_random();
    bit ct = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) ct = ~ct;
      run_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0, ct,
                $urandom_range(0, 3) != 0, $urandom_range(0, 11) != 0);
      n_vec++;
      if (seen() !== expv()) begin
        n_err++; $display("FAIL random c%0d got=%b exp=%b", i, seen(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gapped();
    test_overrun();
    test_block();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
